// File: rtl/exec_pipe_unit.sv
// exec_pipe_unit: Y86-64 execute stage with a single registered output
// (out_valid/val_e/cnd), valid/ready handshakes on both sides, and the
// condition-code register (zf/sf/of).
// Optional feature macro EXEC_MUL_EN: OPq ifun 4 becomes a DATA_W-cycle
// unsigned shift-add multiply. Without it, ifun 4 is an invalid OPq.
module exec_pipe_unit #(
  parameter int DATA_W  = 64,
  parameter int SP_STEP = DATA_W/8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               icode,
  input  logic [3:0]               ifun,
  input  logic signed [DATA_W-1:0] val_a,
  input  logic signed [DATA_W-1:0] val_b,
  input  logic signed [DATA_W-1:0] val_c,
  input  logic                     set_cc_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] val_e,
  output logic                     cnd,
  output logic                     zf,
  output logic                     sf,
  output logic                     of,
  output logic                     busy
);

  localparam int MSB = DATA_W - 1;
  localparam logic [DATA_W-1:0] SP_W = DATA_W'(SP_STEP);

  // Branch / conditional-move predicate from the current flags.
  function automatic logic cond_eval(input logic [3:0] fn, input logic z,
                                     input logic s, input logic o);
    logic lt;
    lt = s ^ o;
    case (fn)
      4'h0:    cond_eval = 1'b1;
      4'h1:    cond_eval = lt | z;
      4'h2:    cond_eval = lt;
      4'h3:    cond_eval = z;
      4'h4:    cond_eval = ~z;
      4'h5:    cond_eval = ~lt;
      4'h6:    cond_eval = ~lt & ~z;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  logic signed [DATA_W-1:0] r_val_e_p1;
  logic                     r_vld_p1;
  logic                     r_cnd_p1;
  logic                     r_zf, r_sf, r_of;

  logic signed [DATA_W-1:0] w_add, w_sub, w_res;
  logic                     w_of, w_cc_wr, w_is_mul, w_cnd, w_acc, w_idle;

  assign w_add = val_b + val_a;
  assign w_sub = val_b - val_a;

  // Single-cycle execute result, overflow and flag-write qualification.
  always_comb begin
    w_res    = '0;
    w_of     = 1'b0;
    w_cc_wr  = 1'b0;
    w_is_mul = 1'b0;
    case (icode)
      4'h2:       w_res = val_a;
      4'h3:       w_res = val_c;
      4'h4, 4'h5: w_res = val_b + val_c;
      4'h6: begin
        case (ifun)
          4'h0: begin
            w_res   = w_add;
            w_cc_wr = 1'b1;
            w_of    = (val_a[MSB] == val_b[MSB]) && (w_add[MSB] != val_a[MSB]);
          end
          4'h1: begin
            w_res   = w_sub;
            w_cc_wr = 1'b1;
            w_of    = (val_a[MSB] != val_b[MSB]) && (w_sub[MSB] != val_b[MSB]);
          end
          4'h2: begin
            w_res   = val_b & val_a;
            w_cc_wr = 1'b1;
          end
          4'h3: begin
            w_res   = val_b ^ val_a;
            w_cc_wr = 1'b1;
          end
`ifdef EXEC_MUL_EN
          4'h4:    w_is_mul = 1'b1;
`endif
          default: w_res = '0;
        endcase
      end
      4'h8, 4'hA: w_res = val_b - SP_W;
      4'h9, 4'hB: w_res = val_b + SP_W;
      default:    w_res = '0;
    endcase
  end

  assign w_cnd = ((icode == 4'h2) || (icode == 4'h7)) ?
                 cond_eval(ifun, r_zf, r_sf, r_of) : 1'b0;

`ifdef EXEC_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_t;
  localparam int CNT_W = $clog2(DATA_W);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mul_cc;
  logic [DATA_W-1:0]  r_mcand, r_mplier, r_macc, w_macc_nxt;
  logic               w_mul_done;

  assign w_idle     = (r_state == S_IDLE);
  assign w_mul_done = (r_state == S_MUL) && (r_cnt == CNT_W'(DATA_W - 1));
  assign w_macc_nxt = r_macc + (r_mplier[0] ? r_mcand : '0);
  assign busy       = (r_state == S_MUL);

  // State register; reset aborts an in-flight multiply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Enter MUL on an accepted multiply, leave after the last shift-add step.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_acc && w_is_mul) w_state_nxt = S_MUL;
      S_MUL:   if (w_mul_done)        w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Step counter and flag-write enable captured at accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_mul_cc <= 1'b0;
    end else if (w_acc && w_is_mul) begin
      r_cnt    <= '0;
      r_mul_cc <= set_cc_en;
    end else if (r_state == S_MUL) begin
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  // Shift-add datapath: one multiplier bit retired per cycle.
  always_ff @(posedge clk) begin
    if (w_acc && w_is_mul) begin
      r_mcand  <= val_b;
      r_mplier <= val_a;
      r_macc   <= '0;
    end else if (r_state == S_MUL) begin
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_macc   <= w_macc_nxt;
    end
  end
`else
  assign w_idle = 1'b1;
  assign busy   = 1'b0;
`endif

  assign in_ready = w_idle & (~r_vld_p1 | out_ready) & ~rst;
  assign w_acc    = in_valid & in_ready;

  // ---- stage p1: output register, held while downstream stalls ----
  // Output register: load on accept/multiply completion, drop valid on consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1   <= 1'b0;
      r_val_e_p1 <= '0;
      r_cnd_p1   <= 1'b0;
    end else if (w_acc && !w_is_mul) begin
      r_vld_p1   <= 1'b1;
      r_val_e_p1 <= w_res;
      r_cnd_p1   <= w_cnd;
`ifdef EXEC_MUL_EN
    end else if (w_mul_done) begin
      r_vld_p1   <= 1'b1;
      r_val_e_p1 <= w_macc_nxt;
      r_cnd_p1   <= 1'b0;
`endif
    end else if (out_ready) begin
      r_vld_p1   <= 1'b0;
    end
  end

  // Condition codes: written by valid OPq (when enabled) at the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zf <= 1'b1;
      r_sf <= 1'b0;
      r_of <= 1'b0;
    end else if (w_acc && w_cc_wr && set_cc_en) begin
      r_zf <= (w_res == '0);
      r_sf <= w_res[MSB];
      r_of <= w_of;
`ifdef EXEC_MUL_EN
    end else if (w_mul_done && r_mul_cc) begin
      r_zf <= (w_macc_nxt == '0);
      r_sf <= w_macc_nxt[MSB];
      r_of <= 1'b0;
`endif
    end
  end

  assign out_valid = r_vld_p1;
  assign val_e     = r_val_e_p1;
  assign cnd       = r_cnd_p1;
  assign zf        = r_zf;
  assign sf        = r_sf;
  assign of        = r_of;

endmodule

// File: tb/tb_exec_pipe_unit.sv
// tb_exec_pipe_unit: directed cases plus randomized instruction stream for
// exec_pipe_unit, checked against a transaction-level reference model.
module tb_exec_pipe_unit;

  localparam int DW  = 64;
  localparam int SPS = DW/8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid, in_ready;
  logic [3:0]    icode, ifun;
  logic [DW-1:0] val_a, val_b, val_c;
  logic          set_cc_en, out_valid, out_ready;
  logic [DW-1:0] val_e;
  logic          cnd, zf, sf, of, busy;

  exec_pipe_unit #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .val_a(val_a), .val_b(val_b), .val_c(val_c),
    .set_cc_en(set_cc_en), .out_valid(out_valid), .out_ready(out_ready),
    .val_e(val_e), .cnd(cnd), .zf(zf), .sf(sf), .of(of), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic          m_vld, m_cnd, m_zf, m_sf, m_of, m_mul_cc;
  logic [DW-1:0] m_val, m_prod;
  int            m_mul_left;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic ref_cond(input logic [3:0] f, input logic z, input logic s, input logic o);
    logic less;
    less = (s != o);
    case (f)
      4'd0: return 1'b1;
      4'd1: return less || z;
      4'd2: return less;
      4'd3: return z;
      4'd4: return !z;
      4'd5: return !less;
      4'd6: return !less && !z;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void ref_exec(input logic [3:0] ic, input logic [3:0] f,
                                   input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic [DW-1:0] c, output logic [DW-1:0] r,
                                   output logic ccw, output logic ovf, output logic ismul);
    logic signed [DW:0] wide;
    r = '0; ccw = 1'b0; ovf = 1'b0; ismul = 1'b0; wide = '0;
    case (ic)
      4'd2:        r = a;
      4'd3:        r = c;
      4'd4, 4'd5:  r = b + c;
      4'd8, 4'd10: r = b - DW'(SPS);
      4'd9, 4'd11: r = b + DW'(SPS);
      4'd6: begin
        case (f)
          4'd0: begin
            wide = $signed({b[DW-1], b}) + $signed({a[DW-1], a});
            r = wide[DW-1:0]; ccw = 1'b1; ovf = (wide[DW] != wide[DW-1]);
          end
          4'd1: begin
            wide = $signed({b[DW-1], b}) - $signed({a[DW-1], a});
            r = wide[DW-1:0]; ccw = 1'b1; ovf = (wide[DW] != wide[DW-1]);
          end
          4'd2: begin r = a & b; ccw = 1'b1; end
          4'd3: begin r = a ^ b; ccw = 1'b1; end
`ifdef EXEC_MUL_EN
          4'd4: begin r = b * a; ismul = 1'b1; end
`endif
          default: r = '0;
        endcase
      end
      default: r = '0;
    endcase
  endfunction

  // One clock: drive at the falling edge, check, advance model, wait a cycle.
  task automatic cyc(input logic iv, input logic [3:0] ic, input logic [3:0] ifn,
                     input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c,
                     input logic cce, input logic ordy);
    logic exp_rdy, acc, ccw, ovf, ismul, cd;
    logic [DW-1:0] r;
    in_valid = iv; icode = ic; ifun = ifn; val_a = a; val_b = b; val_c = c;
    set_cc_en = cce; out_ready = ordy;
    #1;
    exp_rdy = (m_mul_left == 0) && (!m_vld || ordy);
    chk("in_ready",  in_ready,  exp_rdy);
    chk("out_valid", out_valid, m_vld);
    chk("busy",      busy,      m_mul_left > 0);
    chk("val_e",     val_e,     m_val);
    chk("cnd",       cnd,       m_cnd);
    chk("zf",        zf,        m_zf);
    chk("sf",        sf,        m_sf);
    chk("of",        of,        m_of);
    acc = iv && exp_rdy;
    if (m_mul_left > 0) begin
      m_mul_left--;
      if (m_mul_left == 0) begin
        m_vld = 1'b1; m_val = m_prod; m_cnd = 1'b0;
        if (m_mul_cc) begin m_zf = (m_prod == '0); m_sf = m_prod[DW-1]; m_of = 1'b0; end
      end
    end else if (acc) begin
      ref_exec(ic, ifn, a, b, c, r, ccw, ovf, ismul);
      cd = (ic == 4'd2 || ic == 4'd7) ? ref_cond(ifn, m_zf, m_sf, m_of) : 1'b0;
      if (ismul) begin
        m_mul_left = DW; m_prod = r; m_mul_cc = cce; m_vld = 1'b0;
      end else begin
        m_vld = 1'b1; m_val = r; m_cnd = cd;
        if (ccw && cce) begin m_zf = (r == '0); m_sf = r[DW-1]; m_of = ovf; end
      end
    end else if (ordy) begin
      m_vld = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    m_vld = 1'b0; m_val = '0; m_cnd = 1'b0; m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
    m_mul_left = 0; m_mul_cc = 1'b0; m_prod = '0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_val_e",     val_e,     0);
    chk("rst_cnd",       cnd,       0);
    chk("rst_busy",      busy,      0);
    chk("rst_zf",        zf,        1);
    chk("rst_sf",        sf,        0);
    chk("rst_of",        of,        0);
    chk("rst_in_ready",  in_ready,  0);
    repeat (2) @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd_op();
    logic [DW-1:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = {1'b0, {(DW-1){1'b1}}};
      2: v = {1'b1, {(DW-1){1'b0}}};
      3: v = '1;
      4: v = DW'($urandom_range(0, 16));
      default: v = DW'({$urandom, $urandom});
    endcase
    return v;
  endfunction

  logic [DW-1:0] ra, rb, rc;
  logic [3:0]    ric, rif;

  initial begin
    in_valid = 1'b0; icode = '0; ifun = '0; val_a = '0; val_b = '0; val_c = '0;
    set_cc_en = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    do_reset();

    // sub 5-5 then je
    cyc(1, 4'd6, 4'd1, 5, 5, 0, 1, 1);
    chk("sub_val_e", val_e, 0);
    chk("sub_zf", zf, 1);
    chk("sub_sf", sf, 0);
    chk("sub_of", of, 0);
    cyc(1, 4'd7, 4'd3, 0, 0, 0, 1, 1);
    chk("je_cnd", cnd, 1);

    // signed overflow on add, then jl
    cyc(1, 4'd6, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1, 1);
    chk("addov_val_e", val_e, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("addov_sf", sf, 1);
    chk("addov_of", of, 1);
    cyc(1, 4'd7, 4'd2, 0, 0, 0, 1, 1);
    chk("jl_cnd", cnd, 0);

    // add with flag update suppressed
    cyc(1, 4'd6, 4'd0, 0, 0, 0, 0, 1);
    chk("nocc_val_e", val_e, 0);
    chk("nocc_zf", zf, 0);
    chk("nocc_sf", sf, 1);
    chk("nocc_of", of, 1);

    // pushq under backpressure
    cyc(1, 4'd10, 4'd0, 0, 64'h100, 0, 1, 1);
    chk("push_val_e", val_e, 64'hF8);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 4'd3, 4'd0, 0, 0, 64'h55, 1, 0);
      chk("stall_val_e", val_e, 64'hF8);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
    end
    cyc(1, 4'd3, 4'd0, 0, 0, 64'h55, 1, 1);
    chk("after_stall_val_e", val_e, 64'h55);

    // invalid OPq function
    cyc(1, 4'd6, 4'd9, 7, 9, 0, 1, 1);
    chk("badfn_val_e", val_e, 0);
    chk("badfn_cnd", cnd, 0);

`ifdef EXEC_MUL_EN
    cyc(1, 4'd6, 4'd4, 3, 64'h7000, 0, 1, 1);
    for (int i = 0; i < DW; i++) cyc(0, 4'd0, 4'd0, 0, 0, 0, 1, 0);
    chk("mul_val_e", val_e, 64'h15000);
    chk("mul_zf", zf, 0);
    cyc(1, 4'd6, 4'd4, 5, 6, 0, 1, 1);
    for (int i = 0; i < 7; i++) cyc(0, 4'd0, 4'd0, 0, 0, 0, 1, 1);
    do_reset();
    for (int i = 0; i < DW + 4; i++) cyc(0, 4'd0, 4'd0, 0, 0, 0, 1, 1);
    chk("mul_abort_vld", out_valid, 0);
    chk("mul_abort_zf", zf, 1);
`endif

    // randomized stream
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 5))
        0, 1:    ric = 4'd6;
        2:       ric = ($urandom_range(0, 1) != 0) ? 4'd7 : 4'd2;
        default: ric = 4'($urandom_range(0, 15));
      endcase
      rif = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
      ra = rnd_op();
      rb = ($urandom_range(0, 7) == 0) ? ra : rnd_op();
      rc = rnd_op();
      cyc($urandom_range(0, 9) < 8, ric, rif, ra, rb, rc,
          $urandom_range(0, 9) < 9, $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
